// File: rtl/stream_sink_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : stream_sink_pkg                                            |
// | Description : Shared state encoding and saturating-count helper for the  |
// |               stream sink checker.                                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package stream_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned C_SAT_MAX_W = 64;

    // Counts narrower than C_SAT_MAX_W are zero-extended in and truncated out
    // by the caller; 'width' selects where the count saturates.
    function automatic logic [C_SAT_MAX_W-1:0] sat_inc(
        input logic [C_SAT_MAX_W-1:0] value,
        input int unsigned            width
    );
        logic [C_SAT_MAX_W-1:0] w_max;
        if (width >= C_SAT_MAX_W)
            w_max = '1;
        else
            w_max = (C_SAT_MAX_W'(1) << width) - C_SAT_MAX_W'(1);
        return (value >= w_max) ? w_max : value + C_SAT_MAX_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_sink_checker_if.sv
// +--------------------------------------------------------------------------+
// | Module      : stream_sink_checker_if                                     |
// | Description : valid/ready stream bundle between a node and the sink.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

interface stream_sink_checker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             valid_up_in;
    logic             ready_up_out;

    modport master (
        output data_in,
        output valid_up_in,
        input  ready_up_out
    );

    modport slave (
        input  data_in,
        input  valid_up_in,
        output ready_up_out
    );
endinterface

`default_nettype wire

// File: rtl/stream_sink_checker_ready_pattern_gen.sv
// +--------------------------------------------------------------------------+
// | Module      : ready_pattern_gen                                          |
// | Description : Rotating backpressure mask; an all-zero load becomes       |
// |               all-ones so the stream can never deadlock.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module ready_pattern_gen #(
    parameter int PAT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [PAT_W-1:0] i_load_value,
    input  wire logic             i_en,
    output logic                  o_ready_bit
);

    logic [PAT_W-1:0] r_pat_q;
    logic [PAT_W-1:0] w_pat_d;
    logic [PAT_W-1:0] w_pat_rot;

    generate
        if (PAT_W == 1) begin : g_rot_single
            assign w_pat_rot = r_pat_q;
        end else begin : g_rot_multi
            assign w_pat_rot = {r_pat_q[0], r_pat_q[PAT_W-1:1]};
        end
    endgenerate

    always_comb begin
        w_pat_d = r_pat_q;
        if (i_load)
            w_pat_d = (i_load_value == '0) ? '1 : i_load_value;
        else if (i_en)
            w_pat_d = w_pat_rot;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_pat_q <= '0;
        else
            r_pat_q <= w_pat_d;
    end

    assign o_ready_bit = r_pat_q[0];

endmodule

`default_nettype wire

// File: rtl/stream_sink_checker.sv
// +--------------------------------------------------------------------------+
// | Module      : stream_sink_checker                                        |
// | Description : Stream sink with rotating backpressure that checks for an  |
// |               incrementing sequence. Define SINK_PROTOCOL_CHECK_EN to    |
// |               enable valid/data stability checking.                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module stream_sink_checker
    import stream_sink_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16,
    parameter int PAT_W = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [WIDTH-1:0]   start_value,
    input  wire logic [CNT_W-1:0]   beat_target,
    input  wire logic [PAT_W-1:0]   ready_pattern,
    stream_sink_checker_if.slave    up,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        beat_count,
    output logic [CNT_W-1:0]        err_count,
    output logic                    first_err_valid,
    output logic [WIDTH-1:0]        first_err_data,
    output logic [CNT_W-1:0]        proto_err_count
);

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_expected_q, w_expected_d;
    logic [CNT_W-1:0] r_target_q, w_target_d;
    logic [CNT_W-1:0] r_beat_cnt_q, w_beat_cnt_d;
    logic [CNT_W-1:0] r_err_cnt_q, w_err_cnt_d;
    logic             r_first_err_valid_q, w_first_err_valid_d;
    logic [WIDTH-1:0] r_first_err_data_q, w_first_err_data_d;

    logic w_start_ok;
    logic w_run;
    logic w_pat_bit;
    logic w_ready;
    logic w_fire;
    logic w_last;

    assign w_start_ok = start && (r_state_q != ST_RUN);
    assign w_run      = (r_state_q == ST_RUN);
    assign w_ready    = w_run && w_pat_bit;
    assign w_fire     = up.valid_up_in && w_ready;
    assign w_last     = (r_beat_cnt_q == r_target_q - CNT_W'(1));

    ready_pattern_gen #(
        .PAT_W (PAT_W)
    ) u_ready_pattern_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_start_ok),
        .i_load_value (ready_pattern),
        .i_en         (w_run),
        .o_ready_bit  (w_pat_bit)
    );

    always_comb begin
        w_state_d           = r_state_q;
        w_expected_d        = r_expected_q;
        w_target_d          = r_target_q;
        w_beat_cnt_d        = r_beat_cnt_q;
        w_err_cnt_d         = r_err_cnt_q;
        w_first_err_valid_d = r_first_err_valid_q;
        w_first_err_data_d  = r_first_err_data_q;

        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_state_d           = (beat_target == '0) ? ST_DONE : ST_RUN;
                    w_expected_d        = start_value;
                    w_target_d          = beat_target;
                    w_beat_cnt_d        = '0;
                    w_err_cnt_d         = '0;
                    w_first_err_valid_d = 1'b0;
                    w_first_err_data_d  = '0;
                end
            end
            ST_RUN: begin
                if (w_fire) begin
                    w_beat_cnt_d = r_beat_cnt_q + CNT_W'(1);
                    if (up.data_in != r_expected_q) begin
                        w_err_cnt_d = CNT_W'(sat_inc(C_SAT_MAX_W'(r_err_cnt_q), CNT_W));
                        if (!r_first_err_valid_q) begin
                            w_first_err_valid_d = 1'b1;
                            w_first_err_data_d  = up.data_in;
                        end
                    end
                    // Resync on received data so one dropped beat costs one error.
                    w_expected_d = up.data_in + WIDTH'(1);
                    if (w_last)
                        w_state_d = ST_DONE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q           <= ST_IDLE;
            r_expected_q        <= '0;
            r_target_q          <= '0;
            r_beat_cnt_q        <= '0;
            r_err_cnt_q         <= '0;
            r_first_err_valid_q <= 1'b0;
            r_first_err_data_q  <= '0;
        end else begin
            r_state_q           <= w_state_d;
            r_expected_q        <= w_expected_d;
            r_target_q          <= w_target_d;
            r_beat_cnt_q        <= w_beat_cnt_d;
            r_err_cnt_q         <= w_err_cnt_d;
            r_first_err_valid_q <= w_first_err_valid_d;
            r_first_err_data_q  <= w_first_err_data_d;
        end
    end

`ifdef SINK_PROTOCOL_CHECK_EN
    logic             r_prev_valid_q;
    logic             r_prev_ready_q;
    logic [WIDTH-1:0] r_prev_data_q;
    logic [CNT_W-1:0] r_proto_cnt_q, w_proto_cnt_d;
    logic             w_proto_viol;

    // A stalled beat must stay valid and keep its data until accepted.
    always_comb begin
        w_proto_viol = 1'b0;
        if (w_run && r_prev_valid_q && !r_prev_ready_q)
            w_proto_viol = !up.valid_up_in || (up.data_in != r_prev_data_q);
        w_proto_cnt_d = r_proto_cnt_q;
        if (w_start_ok)
            w_proto_cnt_d = '0;
        else if (w_proto_viol)
            w_proto_cnt_d = CNT_W'(sat_inc(C_SAT_MAX_W'(r_proto_cnt_q), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_valid_q <= 1'b0;
            r_prev_ready_q <= 1'b0;
            r_prev_data_q  <= '0;
            r_proto_cnt_q  <= '0;
        end else begin
            r_prev_valid_q <= up.valid_up_in;
            r_prev_ready_q <= w_ready;
            r_prev_data_q  <= up.data_in;
            r_proto_cnt_q  <= w_proto_cnt_d;
        end
    end

    assign proto_err_count = r_proto_cnt_q;
`else
    assign proto_err_count = '0;
`endif

    assign up.ready_up_out  = w_ready;
    assign busy             = w_run;
    assign done             = (r_state_q == ST_DONE);
    assign beat_count       = r_beat_cnt_q;
    assign err_count        = r_err_cnt_q;
    assign first_err_valid  = r_first_err_valid_q;
    assign first_err_data   = r_first_err_data_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_sink_checker.sv
// Scoreboarded bench for stream_sink_checker: a cycle-level source/ready model
// predicts per-cycle ready and the end-of-run counters for each run.
`default_nettype none

module tb_stream_sink_checker;

    localparam int WIDTH  = 32;
    localparam int CNT_W  = 16;
    localparam int PAT_W  = 8;
    localparam int BUDGET = 2000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] start_value = '0;
    logic [CNT_W-1:0] beat_target = '0;
    logic [PAT_W-1:0] ready_pattern = '0;
    logic             busy, done, first_err_valid;
    logic [CNT_W-1:0] beat_count, err_count, proto_err_count;
    logic [WIDTH-1:0] first_err_data;

    always #5 clk = ~clk;

    stream_sink_checker_if #(.WIDTH(WIDTH)) s_if ();

    stream_sink_checker #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .PAT_W (PAT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .start_value     (start_value),
        .beat_target     (beat_target),
        .ready_pattern   (ready_pattern),
        .up              (s_if),
        .busy            (busy),
        .done            (done),
        .beat_count      (beat_count),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_data  (first_err_data),
        .proto_err_count (proto_err_count)
    );

    typedef struct {
        logic [CNT_W-1:0] beats;
        logic [CNT_W-1:0] errs;
        logic             fev;
        logic [WIDTH-1:0] fed;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] sq[$];
    int               vectors = 0;
    int               miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every new entry into DONE retires one predicted run result.
    initial begin : monitor
        logic done_d;
        exp_t e;
        done_d = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_d = 1'b0;
            end else begin
                if (done && !done_d) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_count", 64'(beat_count), 64'(e.beats));
                        check("err_count", 64'(err_count), 64'(e.errs));
                        check("first_err_valid", 64'(first_err_valid), 64'(e.fev));
                        check("first_err_data", 64'(first_err_data), 64'(e.fed));
                        check("proto_err_count", 64'(proto_err_count), 64'd0);
                    end
                end
                done_d = start ? 1'b0 : done;
            end
        end
    end

    task automatic fill_ramp(input logic [WIDTH-1:0] base, input int n);
        sq.delete();
        for (int i = 0; i < n; i++) sq.push_back(base + WIDTH'(i));
    endtask

    task automatic check_all_zero();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(s_if.ready_up_out), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_first_err_valid", 64'(first_err_valid), 64'd0);
        check("rst_first_err_data", 64'(first_err_data), 64'd0);
        check("rst_proto_err_count", 64'(proto_err_count), 64'd0);
    endtask

    // mode 0: continuous valid, 1: valid on even cycles, 2: random valid.
    // A stalled beat is always held until accepted.
    task automatic run(input logic [WIDTH-1:0] sv, input int tgt,
                       input logic [PAT_W-1:0] pat, input int mode, input int abort_after);
        logic [PAT_W-1:0] eff;
        logic [WIDTH-1:0] expv, fed;
        logic             fev, held, v, r, aborted;
        int               idx, acc, errs, k;
        exp_t             e;
        eff = (pat == '0) ? '1 : pat;
        expv = sv; fed = '0; fev = 1'b0; held = 1'b0; aborted = 1'b0;
        idx = 0; acc = 0; errs = 0; k = 0;

        @(posedge clk); #1;
        start = 1'b1; start_value = sv; beat_target = CNT_W'(tgt); ready_pattern = pat;
        s_if.valid_up_in = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; start_value = $urandom; beat_target = CNT_W'($urandom); ready_pattern = PAT_W'($urandom);

        if (tgt == 0) begin
            e.beats = '0; e.errs = '0; e.fev = 1'b0; e.fed = '0;
            exp_q.push_back(e);
        end

        while (acc < tgt) begin
            if (k >= BUDGET) begin
                check("run_timeout", 64'd1, 64'd0);
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = held || (k % 2 == 0);
                default: v = held || ($urandom_range(0, 2) != 0);
            endcase
            if (idx >= sq.size()) v = 1'b0;
            s_if.valid_up_in = v;
            s_if.data_in     = v ? sq[idx] : WIDTH'($urandom);
            r = eff[k % PAT_W];
            @(negedge clk);
            check("ready_cycle", 64'(s_if.ready_up_out), 64'(r));
            if (v && r) begin
                acc++;
                if (sq[idx] != expv) begin
                    errs++;
                    if (!fev) begin fev = 1'b1; fed = sq[idx]; end
                end
                expv = sq[idx] + WIDTH'(1);
                idx++;
                held = 1'b0;
                if (acc == tgt) begin
                    e.beats = CNT_W'(tgt); e.errs = CNT_W'(errs); e.fev = fev; e.fed = fed;
                    exp_q.push_back(e);
                end
            end else begin
                held = v;
            end
            @(posedge clk); #1;
            k++;
            if (abort_after != 0 && acc == abort_after) begin
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            rst = 1'b1; s_if.valid_up_in = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check_all_zero();
        end else begin
            for (int j = 0; j < 2; j++) begin
                s_if.valid_up_in = 1'b1;
                s_if.data_in     = expv;
                @(negedge clk);
                check("ready_after_done", 64'(s_if.ready_up_out), 64'd0);
                check("done_held", 64'(done), 64'd1);
                check("busy_after_done", 64'(busy), 64'd0);
                check("beat_count_hold", 64'(beat_count), 64'(tgt));
                @(posedge clk); #1;
            end
            s_if.valid_up_in = 1'b0;
        end
    endtask

    initial begin : stimulus
        logic [WIDTH-1:0] base, val;
        int               tgt;
        s_if.valid_up_in = 1'b0;
        s_if.data_in     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero();

        fill_ramp(32'd0, 20);   run(32'd0, 20, 8'hFF, 0, 0);
        fill_ramp(32'd100, 16); run(32'd100, 16, 8'b0000_0101, 0, 0);
        fill_ramp(32'd1, 10);   run(32'd1, 10, 8'hFF, 1, 0);

        sq.delete();
        sq.push_back(32'd0); sq.push_back(32'd1); sq.push_back(32'd2);
        sq.push_back(32'd4); sq.push_back(32'd5);
        run(32'd0, 5, 8'hFF, 0, 0);

        sq.delete();
        sq.push_back(32'hFFFF_FFFE); sq.push_back(32'hFFFF_FFFF); sq.push_back(32'h0);
        run(32'hFFFF_FFFE, 3, 8'hFF, 0, 0);

        sq.delete();            run(32'd7, 0, 8'h5A, 0, 0);
        fill_ramp(32'd50, 12);  run(32'd50, 12, 8'h00, 2, 0);

        fill_ramp(32'd0, 10);   run(32'd0, 10, 8'hFF, 0, 3);
        fill_ramp(32'd200, 2);  run(32'd200, 2, 8'h33, 2, 0);

        for (int n = 0; n < 8; n++) begin
            base = $urandom;
            tgt  = $urandom_range(1, 25);
            sq.delete();
            val = base;
            for (int i = 0; i < tgt; i++) begin
                sq.push_back(($urandom_range(0, 11) == 0) ? WIDTH'($urandom) : val);
                val = val + (($urandom_range(0, 7) == 0) ? WIDTH'(2) : WIDTH'(1));
            end
            run(base, tgt, PAT_W'($urandom), $urandom_range(0, 2), 0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
